// File: rtl/bka_wb_seq.sv
// Wishbone-slave multi-word adder: sequences WORDS 16-bit chunks through one bka16, LSB first.
// Optional macro BKA_SEQ_IRQ_EN adds CTRL.IEN and a level done interrupt on irq_o.
module bka16 (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        cin_i,
    output logic [15:0] sum_o,
    output logic        cout_o
);
    logic [15:0]      p0;
    logic [7:0][15:0] gl, pl;
    logic             unused_p;

    assign p0    = a_i ^ b_i;
    assign pl[0] = p0;
    assign gl[0] = (a_i & b_i) | {15'b0, p0[0] & cin_i};

    // Levels 0-3: up-sweep tree; levels 4-6: down-sweep fill-in of the remaining prefixes.
    for (genvar lv = 0; lv < 7; lv++) begin : g_lvl
        for (genvar i = 0; i < 16; i++) begin : g_bit
            localparam int D = (lv < 4) ? (1 << lv) : (1 << (6 - lv));
            localparam bit COMB = (lv < 4) ? (((i + 1) % (2 * D)) == 0)
                                           : ((((i + 1) % (2 * D)) == D) && (i + 1 > 2 * D));
            if (COMB) begin : g_op
                assign gl[lv+1][i] = gl[lv][i] | (pl[lv][i] & gl[lv][i-D]);
                assign pl[lv+1][i] = pl[lv][i] & pl[lv][i-D];
            end else begin : g_pass
                assign gl[lv+1][i] = gl[lv][i];
                assign pl[lv+1][i] = pl[lv][i];
            end
        end
    end

    assign unused_p = ^pl;
    assign sum_o    = p0 ^ {gl[7][14:0], cin_i};
    assign cout_o   = gl[7][15];
endmodule

module bka_wb_seq #(
    parameter int WORDS = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        busy_o,
    output logic        irq_o
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [63:0] MASK = (WORDS >= 4) ? 64'hFFFF_FFFF_FFFF_FFFF
                                                : ((64'd1 << (WORDS * 16)) - 64'd1);
    localparam logic [1:0]  LAST = 2'(WORDS - 1);

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic        carry_q, carry_d, cin_q, cin_d, done_q, done_d, cout_q, cout_d;
    logic        ack_q, ack_d, ien_q;
    logic [63:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [31:0] dat_q, dat_d, rdata, wmask;
    logic [2:0]  adr;
    logic        valid, wr, busy, start;
    logic [15:0] ch_sum;
    logic        ch_cout;
    logic        unused_adr;

    assign valid      = wbs_cyc_i & wbs_stb_i;
    assign adr        = wbs_adr_i[4:2];
    assign wr         = valid & ack_q & wbs_we_i;
    assign busy       = (state_q == RUN);
    assign wmask      = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    assign unused_adr = ^{wbs_adr_i[31:5], wbs_adr_i[1:0]};

    bka16 u_add (
        .a_i   (a_q[{idx_q, 4'b0} +: 16]),
        .b_i   (b_q[{idx_q, 4'b0} +: 16]),
        .cin_i (carry_q),
        .sum_o (ch_sum),
        .cout_o(ch_cout)
    );

`ifdef BKA_SEQ_IRQ_EN
    logic ien_d;
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) ien_q <= 1'b0;
        else          ien_q <= ien_d;
    end
    always_comb begin
        ien_d = ien_q;
        if (wr && adr == 3'd0 && !busy) ien_d = wbs_dat_i[2];
    end
    assign irq_o = done_q & ien_q;
`else
    assign ien_q = 1'b0;
    assign irq_o = 1'b0;
`endif

    always_comb begin
        rdata = 32'b0;
        case (adr)
            3'd0: rdata = {29'b0, ien_q, cin_q, 1'b0};
            3'd1: rdata = {29'b0, cout_q, done_q, busy};
            3'd2: rdata = a_q[31:0];
            3'd3: rdata = a_q[63:32];
            3'd4: rdata = b_q[31:0];
            3'd5: rdata = b_q[63:32];
            3'd6: rdata = sum_q[31:0];
            3'd7: rdata = sum_q[63:32];
            default: rdata = 32'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cin_d   = cin_q;
        done_d  = done_q;
        cout_d  = cout_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        start   = 1'b0;
        ack_d   = valid & ~ack_q;
        dat_d   = ack_d ? rdata : dat_q;

        // Bus writes commit at the end of the ack cycle; config writes are frozen during RUN.
        if (wr) begin
            case (adr)
                3'd0: if (!busy) begin
                    cin_d = wbs_dat_i[1];
                    start = wbs_dat_i[0] && (state_q == IDLE);
                end
                3'd1: if (wbs_dat_i[1]) done_d = 1'b0;
                3'd2: if (!busy) a_d[31:0]  = (a_q[31:0]  & ~wmask) | (wbs_dat_i & wmask);
                3'd3: if (!busy) a_d[63:32] = (a_q[63:32] & ~wmask) | (wbs_dat_i & wmask);
                3'd4: if (!busy) b_d[31:0]  = (b_q[31:0]  & ~wmask) | (wbs_dat_i & wmask);
                3'd5: if (!busy) b_d[63:32] = (b_q[63:32] & ~wmask) | (wbs_dat_i & wmask);
                default: ;
            endcase
        end
        a_d = a_d & MASK;
        b_d = b_d & MASK;

        // FSM follows the bus so completion overrides a same-cycle DONE clear.
        case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                idx_d   = 2'd0;
                carry_d = wbs_dat_i[1];
                done_d  = 1'b0;
                sum_d   = 64'b0;
            end
            RUN: begin
                sum_d[{idx_q, 4'b0} +: 16] = ch_sum;
                carry_d = ch_cout;
                idx_d   = idx_q + 2'd1;
                if (idx_q == LAST) begin
                    state_d = DONE;
                    cout_d  = ch_cout;
                    done_d  = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            carry_q <= 1'b0;
            cin_q   <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            a_q     <= 64'b0;
            b_q     <= 64'b0;
            sum_q   <= 64'b0;
            ack_q   <= 1'b0;
            dat_q   <= 32'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cin_q   <= cin_d;
            done_q  <= done_d;
            cout_q  <= cout_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign busy_o    = busy;
endmodule

// File: tb/tb_bka_wb_seq.sv
// Self-checking bench for bka_wb_seq: directed plan cases plus random additions vs a 65-bit arithmetic model.
module tb_bka_wb_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = 32'h0, dat = 32'h0;
    logic        ack, busy, irq;
    logic [31:0] dat_o;

    int checks = 0;
    int errors = 0;
    int busy_cyc = 0;

    bka_wb_seq #(.WORDS(4)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc),
        .wbs_we_i(we), .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat),
        .wbs_ack_o(ack), .wbs_dat_o(dat_o), .busy_o(busy), .irq_o(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (busy) busy_cyc <= busy_cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic w, input logic [2:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd);
        int n;
        cyc = 1'b1; stb = 1'b1; we = w; adr = {27'b0, a, 2'b0}; dat = d; sel = s;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!ack && n < 20);
        chk("ack_seen", ack, 1);
        rd = dat_o;
        @(posedge clk); #1;
        chk("ack_single", ack, 0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        logic [31:0] x;
        xfer(1'b1, a, d, 4'hF, x);
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        xfer(1'b0, a, 32'h0, 4'hF, d);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 20) begin @(posedge clk); #1; n++; end
        chk("idle_reached", busy, 0);
    endtask

    task automatic load(input logic [63:0] a, input logic [63:0] b);
        wr(3'd2, a[31:0]); wr(3'd3, a[63:32]);
        wr(3'd4, b[31:0]); wr(3'd5, b[63:32]);
    endtask

    function automatic logic exp_irq(input logic done, input logic ien);
`ifdef BKA_SEQ_IRQ_EN
        return done & ien;
`else
        return 1'b0 & done & ien;
`endif
    endfunction

    task automatic check_result(input logic [63:0] a, input logic [63:0] b, input logic cin);
        logic [64:0] ref_v;
        logic [31:0] lo, hi, st;
        ref_v = {1'b0, a} + {1'b0, b} + {64'b0, cin};
        rd(3'd6, lo); rd(3'd7, hi); rd(3'd1, st);
        chk("sum", {hi, lo}, ref_v[63:0]);
        chk("status", {32'b0, st}, {61'b0, ref_v[64], 2'b10});
    endtask

    task automatic do_add(input logic [63:0] a, input logic [63:0] b, input logic cin, input logic ien);
        int b0;
        load(a, b);
        b0 = busy_cyc;
        wr(3'd0, {29'b0, ien, cin, 1'b1});
        chk("busy_after_start", busy, 1);
        wait_idle();
        chk("busy_cycles", busy_cyc - b0, 4);
        chk("irq_done", irq, exp_irq(1'b1, ien));
        check_result(a, b, cin);
    endtask

    initial begin
        logic [31:0] r;
        logic [63:0] ra, rb;
        logic        rc, ri;
        int          b0;

        // Reset state
        #1;
        chk("rst_ack", ack, 0); chk("rst_dat", dat_o, 0);
        chk("rst_busy", busy, 0); chk("rst_irq", irq, 0);
        @(posedge clk); #1; rst = 1'b0;
        rd(3'd1, r); chk("rst_status", r, 0);
        rd(3'd6, r); chk("rst_sum_lo", r, 0);
        rd(3'd0, r); chk("rst_ctrl", r, 0);

        // Byte-lane masking
        wr(3'd2, 32'hFFFF_FFFF);
        xfer(1'b1, 3'd2, 32'h1234_5678, 4'b0101, r);
        rd(3'd2, r); chk("byte_mask", r, 32'hFF34_FF78);

        // Plan cases
        do_add(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0);
        wr(3'd1, 32'h2);
        rd(3'd1, r); chk("w1c_done", r, 0);
        do_add(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
        do_add(64'h0, 64'h0, 1'b1, 1'b0);
        rd(3'd0, r); chk("ctrl_cin", r, 32'h2);
        do_add(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0);

        // W1C landing on the completion edge: completion wins
        load(64'h5, 64'h7);
        wr(3'd0, 32'h1);
        @(posedge clk); #1; @(posedge clk); #1;
        wr(3'd1, 32'h2);
        rd(3'd1, r); chk("w1c_vs_done", r, 32'h2);

        // START and A_LO write during RUN are dropped
        ra = 64'hA5A5_0001_FFFF_1234; rb = 64'h0101_FFFF_0000_EDCC;
        load(ra, rb);
        b0 = busy_cyc;
        wr(3'd0, 32'h1);
        wr(3'd0, 32'h3);
        wr(3'd2, 32'hDEAD_BEEF);
        wait_idle();
        chk("restart_busy_cycles", busy_cyc - b0, 4);
        check_result(ra, rb, 1'b0);
        rd(3'd2, r); chk("a_lo_frozen", r, ra[31:0]);
        rd(3'd0, r); chk("ctrl_frozen", r, 0);

        // Asynchronous reset in RUN cycle 2
        load(64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888);
        wr(3'd0, 32'h1);
        @(posedge clk); #1;
        rst = 1'b1; #1;
        chk("mid_rst_busy", busy, 0); chk("mid_rst_ack", ack, 0);
        chk("mid_rst_dat", dat_o, 0); chk("mid_rst_irq", irq, 0);
        @(posedge clk); #1; rst = 1'b0;
        rd(3'd6, r); chk("mid_rst_sum", r, 0);
        rd(3'd1, r); chk("mid_rst_status", r, 0);
        rd(3'd2, r); chk("mid_rst_a", r, 0);
        do_add(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b1, 1'b0);

        // Interrupt enable and clear
        do_add(64'h42, 64'h24, 1'b0, 1'b1);
        wr(3'd1, 32'h2);
        chk("irq_cleared", irq, 0);

        // Random additions
        for (int k = 0; k < 8; k++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rc = 1'($urandom_range(0, 1));
            ri = 1'($urandom_range(0, 1));
            do_add(ra, rb, rc, ri);
            wr(3'd1, 32'h2);
            chk("rand_irq_clr", irq, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bka_wb_seq.md
Name: bka_wb_seq

Overview:
- Wishbone-slave sequencer that performs multi-word additions (up to 64 bits) by time-multiplexing one bka16 16-bit Brent-Kung adder instance.
- Operands are loaded over Wishbone and a start is issued. The FSM feeds one 16-bit chunk per cycle, LSB chunk first, and registers the carry between chunks.
- Sits in user_proj_example between the Wishbone bus and bka16. Replaces the direct LA/IO hookup with a sequenced, bus-visible datapath.

Parameters:
- WORDS, 4, number of 16-bit chunks per operation (legal 1..4). Operand width is WORDS*16; bits above it read 0 and ignore writes.

Ports:
- wb_clk_i  input  1  system clock; all state on rising edge
- wb_rst_i  input  1  asynchronous, active-high reset
- wbs_stb_i  input  1  Wishbone strobe
- wbs_cyc_i  input  1  Wishbone cycle
- wbs_we_i  input  1  write enable
- wbs_sel_i  input  4  byte lane selects
- wbs_adr_i  input  32  address; only [4:2] decoded
- wbs_dat_i  input  32  write data
- wbs_ack_o  output  1  single-cycle acknowledge
- wbs_dat_o  output  32  read data
- busy_o  output  1  high while sequencing
- irq_o  output  1  done interrupt (see Optional Feature)

Behaviour:
- Reset (asynchronous, wb_rst_i=1): FSM=IDLE; A, B, SUM, chunk index, carry, cin, done, cout all 0; wbs_ack_o=0; wbs_dat_o=0; busy_o=0; irq_o=0.
- Register map, by wbs_adr_i[4:2]:
  - 0 CTRL: bit0 START (write-1 pulse, reads 0); bit1 CIN (R/W).
  - 1 STATUS: bit0 BUSY (RO); bit1 DONE (W1C); bit2 COUT (RO).
  - 2 A_LO, 3 A_HI, 4 B_LO, 5 B_HI: R/W, byte-masked by wbs_sel_i.
  - 6 SUM_LO, 7 SUM_HI: RO.
- Bus handshake:
  - valid = cyc & stb.
  - wbs_ack_o rises one cycle after valid and lasts exactly one cycle. No ack in the cycle after an ack, so a held request is acked every 2nd cycle.
  - Write side effects and read data are taken in the ack cycle. wbs_dat_o is registered and holds its value between acks.
- FSM states and transitions:
  - IDLE: a START=1 write moves to RUN. Same edge: idx=0, carry=CIN, done=0, SUM=0.
  - RUN: each cycle, bka16 takes a=A[idx*16+:16], b=B[idx*16+:16], cin=carry. Then SUM[idx*16+:16]<=sum, carry<=carryout, idx<=idx+1. After chunk WORDS-1, go to DONE with COUT=final carryout.
  - DONE: a single cycle. Sets done=1, returns to IDLE.
- Latency: busy_o is high exactly WORDS cycles, starting the cycle after the START ack. DONE is visible on cycle WORDS+1.
- Boundary rules:
  - START while busy is ignored; no restart.
  - A/B/CTRL writes while busy are acked but dropped. A/B are stable during RUN.
  - Reads of SUM while busy return partial results; not an error.
  - DONE W1C write and completion in the same cycle: completion wins, DONE=1.
  - START write with CIN bit also set: the new CIN is used for this run.
  - Unmapped bits read 0. Addresses outside [4:2] decode alias by design.
  - Reset mid-RUN aborts immediately: SUM=0, DONE=0.
- Arithmetic: unsigned, modulo 2^(WORDS*16). Overflow is reported only via COUT.

Optional Feature:
- Macro: BKA_SEQ_IRQ_EN.
- Defined: irq_o = DONE & IEN. IEN is CTRL bit2 (R/W, reset 0). The interrupt is level-sensitive and cleared by the DONE W1C or by the next START.
- Undefined: irq_o is tied 0. CTRL bit2 reads 0 and ignores writes.

Test Plan:
- A=0x0000_0000_0000_FFFF, B=0x1, CIN=0, START -> busy_o high 4 cycles; SUM=0x0000_0000_0001_0000, COUT=0, DONE=1.
- A=0xFFFF_FFFF_FFFF_FFFF, B=0x1, START -> SUM=0x0, COUT=1; ripple through all 4 chunks checked.
- A=B=0, CIN=1 -> SUM=0x1. A=0x1234_5678_9ABC_DEF0, B=0x0FED_CBA9_8765_4321, CIN=0 -> SUM=0x2222_2222_2222_2211, COUT=0.
- START issued again at RUN cycle 2, plus an A_LO write during RUN -> both ignored; result matches the original operands; busy duration still 4 cycles.
- wb_rst_i asserted during RUN cycle 2 -> all outputs and registers 0 asynchronously; a fresh START then completes normally.
- With BKA_SEQ_IRQ_EN, IEN=1 -> irq_o rises with DONE; writing STATUS=0x2 clears it. Without the macro -> irq_o stays 0 throughout.
